lif_layer: RTL and testbench

- Parametrised successor to the single-step IF network layer: one layer of NUM_NEURONS leaky integrate-and-fire neurons, each with NUM_INPUTS signed synapses.
- Time-multiplexed: one shared accumulator walks neurons and inputs serially per timestep.
- Adds a run-time writable weight RAM, a shift-based leak, refractory counters, saturating membranes and valid/ready timestep handshakes.
- Instances are chained layer-to-layer inside the network top.

---
 rtl/lif_layer.sv | 205 ++++++++++++++++++++
 tb/tb_lif_layer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer.sv
// lif_layer: one layer of leaky integrate-and-fire neurons sharing one serial accumulator.
// Latency: out_valid rises NUM_NEURONS*(NUM_INPUTS+1) cycles after the accepting edge.
// Backpressure: results held in DONE until out_ready; in_ready is low outside IDLE.
// Optional: define LIF_LAYER_SPIKE_COUNT_EN for per-neuron spike counters with a registered read port.
module lif_layer #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_NEURONS = 4,
    parameter int WEIGHT_SIZE = 8,
    parameter int V_WIDTH     = 16,
    parameter int THRESH      = 100,
    parameter int RESET_V     = 0,
    parameter int REFRAC      = 2,
    parameter int LEAK_SHIFT  = 0,
    localparam int DEPTH = NUM_NEURONS * NUM_INPUTS,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_INPUTS-1:0]         spike_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_NEURONS-1:0]        spike_out,
    input  logic                          w_wr_en,
    input  logic [AW-1:0]                 w_wr_addr,
    input  logic signed [WEIGHT_SIZE-1:0] w_wr_data,
    input  logic                          clear_state
`ifdef LIF_LAYER_SPIKE_COUNT_EN
    ,
    input  logic [NW-1:0]                 cnt_addr,
    output logic [15:0]                   cnt_data,
    input  logic                          cnt_clear
`endif
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESH);
    localparam logic signed [V_WIDTH-1:0] RST_V    = V_WIDTH'(RESET_V);
    localparam logic signed [V_WIDTH-1:0] V_MAX    = {1'b0, {(V_WIDTH-1){1'b1}}};
    localparam logic signed [V_WIDTH-1:0] V_MIN    = {1'b1, {(V_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

    state_t state, state_nx;

    logic [NW-1:0]                 n_idx;
    logic [IW-1:0]                 i_idx;
    logic [NUM_INPUTS-1:0]         spike_lat;
    logic signed [V_WIDTH-1:0]     acc;
    logic signed [V_WIDTH-1:0]     v_mem      [NUM_NEURONS];
    logic [RW-1:0]                 refrac_cnt [NUM_NEURONS];
    logic signed [WEIGHT_SIZE-1:0] w_mem      [DEPTH];
    logic [NUM_NEURONS-1:0]        spike_vec;

    logic [AW-1:0]                 w_rd_addr;
    logic signed [WEIGHT_SIZE-1:0] w_rd;
    logic signed [V_WIDTH-1:0]     acc_base;
    logic signed [V_WIDTH:0]       acc_ext;
    logic signed [V_WIDTH:0]       w_ext;
    logic signed [V_WIDTH:0]       sum_wide;
    logic signed [V_WIDTH-1:0]     acc_sum;
    logic signed [V_WIDTH-1:0]     leak_v;
    logic                          in_refrac;
    logic                          upd_fire;
    logic signed [V_WIDTH-1:0]     upd_v;
    logic [NUM_NEURONS-1:0]        spike_nx;
    logic                          last_input;
    logic                          last_neuron;

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign last_input  = (i_idx == IW'(NUM_INPUTS - 1));
    assign last_neuron = (n_idx == NW'(NUM_NEURONS - 1));
    assign w_rd_addr   = AW'(int'(n_idx) * NUM_INPUTS + int'(i_idx));
    assign w_rd        = w_mem[w_rd_addr];

    // Saturating accumulate step; the running sum starts from the neuron's membrane on input 0.
    always_comb begin
        acc_base = (i_idx == '0) ? v_mem[n_idx] : acc;
        acc_ext  = {acc_base[V_WIDTH-1], acc_base};
        w_ext    = {{(V_WIDTH+1-WEIGHT_SIZE){w_rd[WEIGHT_SIZE-1]}}, w_rd};
        sum_wide = acc_ext + (spike_lat[i_idx] ? w_ext : '0);
        if (sum_wide[V_WIDTH] != sum_wide[V_WIDTH-1]) begin
            acc_sum = sum_wide[V_WIDTH] ? V_MIN : V_MAX;
        end else begin
            acc_sum = sum_wide[V_WIDTH-1:0];
        end
    end

    // Per-neuron update decision: refractory hold, fire, or leaky carry-over of the sum.
    always_comb begin
        leak_v    = (LEAK_SHIFT == 0) ? acc : (acc - (acc >>> LEAK_SHIFT));
        in_refrac = (refrac_cnt[n_idx] != '0);
        upd_fire  = !in_refrac && (acc >= THRESH_V);
        upd_v     = (in_refrac || upd_fire) ? RST_V : leak_v;
        spike_nx  = spike_vec;
        spike_nx[n_idx] = upd_fire;
    end

    // Next-state logic for the timestep walk.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!clear_state && in_valid) state_nx = S_ACCUM;
            S_ACCUM:  if (last_input) state_nx = S_UPDATE;
            S_UPDATE: state_nx = last_neuron ? S_DONE : S_ACCUM;
            S_DONE:   if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: indices, accumulator, membranes, refractory counters and spike outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_idx     <= '0;
            i_idx     <= '0;
            spike_lat <= '0;
            acc       <= '0;
            spike_vec <= '0;
            spike_out <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k]      <= RST_V;
                refrac_cnt[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_state) begin
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            v_mem[k]      <= RST_V;
                            refrac_cnt[k] <= '0;
                        end
                    end else if (in_valid) begin
                        spike_lat <= spike_in;
                        n_idx     <= '0;
                        i_idx     <= '0;
                    end
                end
                S_ACCUM: begin
                    acc   <= acc_sum;
                    i_idx <= last_input ? '0 : i_idx + 1'b1;
                end
                S_UPDATE: begin
                    v_mem[n_idx] <= upd_v;
                    spike_vec    <= spike_nx;
                    if (in_refrac) begin
                        refrac_cnt[n_idx] <= refrac_cnt[n_idx] - 1'b1;
                    end else if (upd_fire) begin
                        refrac_cnt[n_idx] <= RW'(REFRAC);
                    end
                    if (last_neuron) begin
                        spike_out <= spike_nx;
                    end else begin
                        n_idx <= n_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight RAM: writable only while idle, out-of-range addresses dropped; not reset.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && w_wr_en &&
            ({{(32-AW){1'b0}}, w_wr_addr} < 32'(DEPTH))) begin
            w_mem[w_wr_addr] <= w_wr_data;
        end
    end

`ifdef LIF_LAYER_SPIKE_COUNT_EN
    logic [15:0] spk_cnt [NUM_NEURONS];

    // Saturating per-neuron spike counters; clear beats a same-cycle increment. Read is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_data <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                spk_cnt[k] <= '0;
            end
        end else begin
            if (cnt_clear) begin
                for (int k = 0; k < NUM_NEURONS; k++) begin
                    spk_cnt[k] <= '0;
                end
            end else if ((state == S_UPDATE) && upd_fire && (spk_cnt[n_idx] != 16'hFFFF)) begin
                spk_cnt[n_idx] <= spk_cnt[n_idx] + 16'd1;
            end
            cnt_data <= spk_cnt[cnt_addr];
        end
    end
`endif

endmodule

// File: tb/tb_lif_layer.sv
// tb_lif_layer: directed checks of the LIF layer at defaults plus a LEAK_SHIFT=2 instance.
// Both instances share all inputs; each timestep is driven from IDLE and awaited with a bound.
// Counter checks are compiled in only when LIF_LAYER_SPIKE_COUNT_EN is defined.
module tb_lif_layer;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [7:0]        spike_in = 8'h00;
    logic              w_wr_en = 1'b0;
    logic [4:0]        w_wr_addr = 5'd0;
    logic signed [7:0] w_wr_data = 8'sd0;
    logic              clear_state = 1'b0;

    wire               in_ready, out_valid, in_ready2, out_valid2;
    wire [3:0]         spike_out, spike_out2;

`ifdef LIF_LAYER_SPIKE_COUNT_EN
    logic [1:0]        cnt_addr = 2'd0;
    logic              cnt_clear = 1'b0;
    wire [15:0]        cnt_data, cnt_data2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_layer dut (
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        .cnt_addr(cnt_addr), .cnt_data(cnt_data), .cnt_clear(cnt_clear),
`endif
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .spike_in(spike_in),
        .out_valid(out_valid), .out_ready(out_ready), .spike_out(spike_out),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .clear_state(clear_state)
    );

    lif_layer #(.LEAK_SHIFT(2)) dut_leak (
`ifdef LIF_LAYER_SPIKE_COUNT_EN
        .cnt_addr(cnt_addr), .cnt_data(cnt_data2), .cnt_clear(cnt_clear),
`endif
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .spike_in(spike_in),
        .out_valid(out_valid2), .out_ready(out_ready), .spike_out(spike_out2),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .clear_state(clear_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input int addr, input logic signed [7:0] w);
        w_wr_en = 1'b1; w_wr_addr = 5'(addr); w_wr_data = w;
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic write_all(input logic signed [7:0] w);
        for (int a = 0; a < 32; a++) write_one(a, w);
    endtask

    task automatic clear();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
    endtask

    task automatic start_ts(input logic [7:0] s);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        spike_in = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_ts(output logic [3:0] so, output logic [3:0] so2, output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        so = spike_out; so2 = spike_out2;
        if (out_ready) tick();
    endtask

    // finish_ts counts from the first cycle after the accept edge; lat ends at the edge count.
    task automatic run_ts(input logic [7:0] s, output logic [3:0] so, output logic [3:0] so2, output int lat);
        start_ts(s);
        tick();
        finish_ts(so, so2, lat);
    endtask

    logic [3:0] so, so2;
    int         lat, first;
    logic [3:0] fso;
    logic [3:0] exp_s1 [6] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] exp_lk [4] = '{4'h0, 4'h0, 4'h0, 4'hF};
    logic [3:0] exp_lm [4] = '{4'h0, 4'h0, 4'hF, 4'h0};

    initial begin
        // Reset values while reset is held.
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_spike_out", 32'(spike_out), 32'd0);
        #11 rst = 1'b1;
        tick();

        // Pure IF with refractory: W=60, one active input.
        write_all(8'sd60);
        for (int t = 0; t < 6; t++) begin
            run_ts(8'h01, so, so2, lat);
            check($sformatf("if_spike_t%0d", t), 32'(so), 32'(exp_s1[t]));
            check($sformatf("if_leak_spike_t%0d", t), 32'(so2), 32'(exp_s1[t]));
            check($sformatf("if_latency_t%0d", t), 32'(lat), 32'd36);
        end

`ifdef LIF_LAYER_SPIKE_COUNT_EN
        for (int n = 0; n < 4; n++) begin
            cnt_addr = 2'(n);
            tick();
            check($sformatf("cnt_n%0d", n), 32'(cnt_data), 32'd2);
        end
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cnt_addr = 2'(n);
            tick();
            check($sformatf("cnt_cleared_n%0d", n), 32'(cnt_data), 32'd0);
        end
`endif

        // Leak: W=40; leak instance goes 30, 53, 70 then fires; pure IF fires on the third step.
        write_all(8'sd40);
        clear();
        for (int t = 0; t < 4; t++) begin
            run_ts(8'h01, so, so2, lat);
            check($sformatf("leak_spike_t%0d", t), 32'(so2), 32'(exp_lk[t]));
            check($sformatf("leak_ref_spike_t%0d", t), 32'(so), 32'(exp_lm[t]));
        end

        // Backpressure: hold results in DONE for 10 cycles with in_valid asserted.
        clear();
        out_ready = 1'b0;
        start_ts(8'hFF);
        tick();
        finish_ts(so, so2, lat);
        check("bp_spike", 32'(so), 32'hF);
        check("bp_latency", 32'(lat), 32'd36);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold_c%0d", c), {26'd0, out_valid, in_ready, spike_out}, {26'd0, 1'b1, 1'b0, 4'hF});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {26'd0, out_valid, in_ready, spike_out}, {26'd0, 1'b0, 1'b1, 4'hF});

        // Weight write during ACCUM is dropped; the next timestep still sees W[0][0]=60.
        write_all(8'sd60);
        clear();
        run_ts(8'h01, so, so2, lat);
        check("wr_accum_pre", 32'(so), 32'h0);
        start_ts(8'h01);
        tick(); tick(); tick();
        write_one(0, -8'sd128);
        finish_ts(so, so2, lat);
        check("wr_accum_ignored", 32'(so), 32'hF);

        // Idle write to neuron 2 input 3 only affects spike_out[2].
        clear();
        write_one(2 * 8 + 3, 8'sd127);
        run_ts(8'h08, so, so2, lat);
        check("wr_idle_n2", 32'(so), 32'h4);
        check("wr_idle_n2_leak", 32'(so2), 32'h4);
        write_one(2 * 8 + 3, 8'sd60);

        // Async reset mid-ACCUM after a spike left neurons refractory.
        clear();
        run_ts(8'h01, so, so2, lat);
        run_ts(8'h01, so, so2, lat);
        check("arst_pre_spike", 32'(so), 32'hF);
        start_ts(8'h01);
        tick(); tick(); tick(); tick();
        #2 rst = 1'b0;
        #1;
        check("arst_immediate", {29'd0, in_ready, out_valid, spike_out != 4'h0}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        check("arst_held_no_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        run_ts(8'h01, so, so2, lat);
        check("arst_fresh_t0", 32'(so), 32'h0);
        check("arst_fresh_latency", 32'(lat), 32'd36);
        run_ts(8'h01, so, so2, lat);
        check("arst_fresh_t1", 32'(so), 32'hF);

        // Saturation: -1024 per step clamps at -32768 without wrapping, then +1016 per step.
        write_all(-8'sd128);
        clear();
        for (int t = 0; t < 40; t++) begin
            run_ts(8'hFF, so, so2, lat);
            check($sformatf("sat_neg_t%0d", t), 32'(so), 32'h0);
        end
        write_all(8'sd127);
        first = 0;
        fso = 4'h0;
        for (int k = 1; k <= 36; k++) begin
            run_ts(8'hFF, so, so2, lat);
            if (first == 0 && so != 4'h0) begin
                first = k;
                fso = so;
            end
        end
        check("sat_first_spike_ts", 32'(first), 32'd33);
        check("sat_first_spike_val", 32'(fso), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
